// File: rtl/pixel_spi_streamer_pkg.sv
// Shared types and constants for the pixel-to-SPI streamer.
// Optional build macro PIXEL_SPI_FRAME_CS_EN keeps chip select low across a whole frame.
package pixel_spi_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam int          BitsPerByte       = 8;
  localparam logic [15:0] FrameBytesDefault = 16'd38400;
endpackage

// File: rtl/pixel_spi_streamer_if.sv
// Pixel stream handshake plus SPI pins; master = pixel source / display side, slave = streamer.
interface pixel_spi_streamer_if;
  logic den_i;
  logic pix_i;
  logic rdy_o;
  logic spi_sck_o;
  logic spi_mosi_o;
  logic spi_cs_n_o;
  logic busy_o;

  modport master (output den_i, pix_i,
                  input  rdy_o, spi_sck_o, spi_mosi_o, spi_cs_n_o, busy_o);
  modport slave  (input  den_i, pix_i,
                  output rdy_o, spi_sck_o, spi_mosi_o, spi_cs_n_o, busy_o);
endinterface

// File: rtl/pixel_spi_streamer_tx.sv
// Mode-0 SPI byte transmitter: IDLE/SHIFT/GAP FSM with SCK divider and MSB-first shifter.
// Under PIXEL_SPI_FRAME_CS_EN a byte counter holds cs_n low for FrameBytes bytes.
module spi_byte_tx
  import pixel_spi_pkg::*;
#(
  parameter logic [7:0]  ClkDiv     = 8'd2
`ifdef PIXEL_SPI_FRAME_CS_EN
  , parameter logic [15:0] FrameBytes = FrameBytesDefault
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       idle_o,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       cs_n_o
);
  localparam int             DivW    = $clog2(int'(ClkDiv) + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 8'd1);
  localparam logic [2:0]     LastBit = 3'(BitsPerByte - 1);

  tx_state_e       state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic            sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic [7:0]      sr_q, sr_d;
  logic            div_term;
`ifdef PIXEL_SPI_FRAME_CS_EN
  localparam logic [15:0] FrameLast = FrameBytes - 16'd1;
  logic [15:0] byte_q, byte_d;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
`ifdef PIXEL_SPI_FRAME_CS_EN
      byte_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
`ifdef PIXEL_SPI_FRAME_CS_EN
      byte_q  <= byte_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    sr_q <= sr_d;
  end

  assign div_term = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    sr_d    = sr_q;
`ifdef PIXEL_SPI_FRAME_CS_EN
    byte_d  = byte_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load_i) begin
          state_d = SHIFT;
          sr_d    = data_i;
          cs_n_d  = 1'b0;
          mosi_d  = data_i[7];
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (!div_term) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == LastBit) begin
              mosi_d = 1'b0;
              bit_d  = '0;
`ifdef PIXEL_SPI_FRAME_CS_EN
              // Mid-frame bytes skip the gap so cs_n stays asserted.
              if (byte_q == FrameLast) begin
                state_d = GAP;
                cs_n_d  = 1'b1;
                byte_d  = '0;
              end else begin
                state_d = IDLE;
                byte_d  = byte_q + 16'd1;
              end
`else
              state_d = GAP;
              cs_n_d  = 1'b1;
`endif
            end else begin
              sr_d   = {sr_q[6:0], 1'b0};
              mosi_d = sr_q[6];
              bit_d  = bit_q + 3'd1;
            end
          end
        end
      end
      GAP: begin
        if (div_term) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle_o = (state_q == IDLE);
    sck_o  = sck_q;
    mosi_o = mosi_q;
    cs_n_o = cs_n_q;
  end
endmodule

// File: rtl/pixel_spi_streamer.sv
// Packs accepted 1-bit pixels MSB-first into bytes and hands them to the SPI transmitter.
// Build macro PIXEL_SPI_FRAME_CS_EN selects frame-wide chip select in the transmitter.
module pixel_spi_streamer
  import pixel_spi_pkg::*;
#(
  parameter logic [7:0]  ClkDiv     = 8'd2,
  parameter logic [15:0] FrameBytes = FrameBytesDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pixel_spi_streamer_if.slave  bus
);
  localparam logic [2:0] LastPix = 3'(BitsPerByte - 1);

  if (ClkDiv == 8'd0 || FrameBytes == 16'd0) begin : g_bad_cfg
    $error("pixel_spi_streamer: ClkDiv and FrameBytes must be nonzero");
  end

  logic [7:0] pack_q, pack_d;
  logic [2:0] pack_cnt_q, pack_cnt_d;
  logic       pack_full_q, pack_full_d;
  logic       accept, load, tx_idle;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pack_cnt_q  <= '0;
      pack_full_q <= 1'b0;
    end else begin
      pack_cnt_q  <= pack_cnt_d;
      pack_full_q <= pack_full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pack_q <= pack_d;
  end

  // Accept and hand-off are exclusive: one needs the packer empty, the other full.
  assign accept = !pack_full_q && bus.den_i;
  assign load   = pack_full_q && tx_idle;

  always_comb begin
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    pack_full_d = pack_full_q;
    if (accept) begin
      pack_d     = {pack_q[6:0], bus.pix_i};
      pack_cnt_d = pack_cnt_q + 3'd1;
      if (pack_cnt_q == LastPix) pack_full_d = 1'b1;
    end
    if (load) pack_full_d = 1'b0;
  end

  assign bus.rdy_o  = !pack_full_q;
  assign bus.busy_o = !tx_idle || pack_full_q;

  spi_byte_tx #(
    .ClkDiv     (ClkDiv)
`ifdef PIXEL_SPI_FRAME_CS_EN
    , .FrameBytes (FrameBytes)
`endif
  ) u_tx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .data_i (pack_q),
    .idle_o (tx_idle),
    .sck_o  (bus.spi_sck_o),
    .mosi_o (bus.spi_mosi_o),
    .cs_n_o (bus.spi_cs_n_o)
  );
endmodule

// File: tb/tb_pixel_spi_streamer.sv
// Directed bench for pixel_spi_streamer with ClkDiv=2, FrameBytes=4.
module tb_pixel_spi_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pixel_spi_streamer_if bus();

  pixel_spi_streamer #(.ClkDiv(8'd2), .FrameBytes(16'd4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stall    = 0;

  logic [7:0] rxq[$];
  int         rises    = 0;
  int         cs_rises = 0;
  int         nb       = 0;
  logic [7:0] sh       = 8'h00;
  logic       sck_prev = 1'b0;
  logic       cs_prev  = 1'b1;

  // SPI slave model: captures MOSI on each SCK rise, counts cs_n rises
  always @(posedge clk) begin
    if (rst) begin
      nb       = 0;
      sck_prev = bus.spi_sck_o;
      cs_prev  = bus.spi_cs_n_o;
    end else begin
      if (bus.spi_sck_o === 1'b1 && sck_prev === 1'b0) begin
        sh = {sh[6:0], bus.spi_mosi_o};
        nb++;
        rises++;
        if (nb == 8) begin
          rxq.push_back(sh);
          nb = 0;
        end
      end
      if (bus.spi_cs_n_o === 1'b1 && cs_prev === 1'b0) cs_rises++;
      sck_prev = bus.spi_sck_o;
      cs_prev  = bus.spi_cs_n_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic d, input logic p);
    int w;
    @(negedge clk);
    bus.den_i = d;
    bus.pix_i = p;
    w = 0;
    while (bus.rdy_o !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
      stall++;
    end
    if (w >= 200) chk("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send(1'b1, b[i]);
  endtask

  task automatic drive_idle();
    @(negedge clk);
    bus.den_i = 1'b0;
    bus.pix_i = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int w = 0;
    while (rxq.size() < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (rxq.size() < n) chk("byte_timeout", rxq.size(), n);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (bus.busy_o !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    chk(tag, {24'd0, got}, {24'd0, exp});
  endtask

  initial begin
    int r0, c0, s, w;
    logic [7:0] frame_exp[4];
    logic [7:0] seq_exp[4];
    logic d, p;
    frame_exp[0] = 8'hFF; frame_exp[1] = 8'h81; frame_exp[2] = 8'h81; frame_exp[3] = 8'hFF;
    seq_exp[0] = 8'h11; seq_exp[1] = 8'h22; seq_exp[2] = 8'h33; seq_exp[3] = 8'h44;

    bus.den_i = 1'b0;
    bus.pix_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy", bus.rdy_o, 1);
    chk("rst_sck", bus.spi_sck_o, 0);
    chk("rst_mosi", bus.spi_mosi_o, 0);
    chk("rst_cs_n", bus.spi_cs_n_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    rst = 1'b0;

    // Reset mid-SHIFT while SCK is high
    send_byte(8'hFF);
    drive_idle();
    w = 0;
    while (bus.spi_sck_o !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("sck_high_seen", bus.spi_sck_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sck", bus.spi_sck_o, 0);
    chk("async_rst_cs_n", bus.spi_cs_n_o, 1);
    chk("async_rst_rdy", bus.rdy_o, 1);
    chk("async_rst_busy", bus.busy_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxq.delete();
    r0 = rises;
    repeat (40) @(negedge clk);
    chk("post_rst_no_sck", rises - r0, 0);
    chk("post_rst_no_byte", rxq.size(), 0);
    chk("post_rst_cs_n", bus.spi_cs_n_o, 1);

    // Single byte 1,0,1,1,0,0,1,0 -> 0xB2
    r0 = rises;
    c0 = cs_rises;
    send_byte(8'hB2);
    drive_idle();
    chk("b2_rdy_full", bus.rdy_o, 0);
    chk("b2_busy_full", bus.busy_o, 1);
    @(negedge clk);
    chk("b2_rdy_after_load", bus.rdy_o, 1);
    chk("b2_cs_low", bus.spi_cs_n_o, 0);
    repeat (31) @(negedge clk);
    chk("b2_cs_low_last", bus.spi_cs_n_o, 0);
    @(negedge clk);
`ifndef PIXEL_SPI_FRAME_CS_EN
    chk("b2_cs_gap", bus.spi_cs_n_o, 1);
    @(negedge clk);
    chk("b2_busy_gap", bus.busy_o, 1);
    @(negedge clk);
    chk("b2_busy_done", bus.busy_o, 0);
`else
    chk("b2_cs_held", bus.spi_cs_n_o, 0);
    chk("b2_busy_done", bus.busy_o, 0);
`endif
    wait_bytes(1);
    chk_byte("b2_byte", 8'hB2);
    chk("b2_rises", rises - r0, 8);
`ifndef PIXEL_SPI_FRAME_CS_EN
    chk("b2_cs_rises", cs_rises - c0, 1);
`endif

    // Back-to-back 16 pixels, stall until transmitter returns to IDLE
    wait_idle();
    stall = 0;
    send_byte(8'hA5);
    send_byte(8'h3C);
    chk("b2b_first_stall", stall, 1);
    drive_idle();
    s = 0;
    while (bus.rdy_o !== 1'b1 && s < 200) begin
      s++;
      @(negedge clk);
    end
`ifndef PIXEL_SPI_FRAME_CS_EN
    chk("b2b_second_stall", s, 27);
`else
    chk("b2b_second_stall", s, 25);
`endif
    wait_bytes(2);
    chk_byte("b2b_byte0", 8'hA5);
    chk_byte("b2b_byte1", 8'h3C);

    // Blanking samples are discarded
    wait_idle();
    r0 = rises;
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    drive_idle();
    repeat (10) @(negedge clk);
    chk("blank_busy", bus.busy_o, 0);
    chk("blank_no_sck", rises - r0, 0);
`ifndef PIXEL_SPI_FRAME_CS_EN
    chk("blank_cs_n", bus.spi_cs_n_o, 1);
`endif
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b1); send(1'b1, 1'b1);
    send(1'b0, 1'b1); send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b0);
    send(1'b0, 1'b1); send(1'b1, 1'b0); send(1'b1, 1'b1);
    drive_idle();
    wait_bytes(1);
    chk_byte("blank_mix_byte", 8'hF1);

    // Generator model: 8x4 active, 12x6 total, border pattern, two frames
    wait_idle();
    for (int f = 0; f < 2; f++) begin
      for (int row = 0; row < 6; row++) begin
        for (int col = 0; col < 12; col++) begin
          d = (row < 4) && (col < 8);
          p = d && (row == 0 || row == 3 || col == 0 || col == 7);
          send(d, p);
        end
      end
    end
    drive_idle();
    wait_bytes(8);
    for (int i = 0; i < 8; i++) chk_byte($sformatf("gen_byte%0d", i), frame_exp[i % 4]);

    // Four bytes streamed continuously: one frame under frame-wide cs_n
    wait_idle();
    repeat (4) @(negedge clk);
    c0 = cs_rises;
    for (int i = 0; i < 4; i++) send_byte(seq_exp[i]);
    drive_idle();
    wait_bytes(4);
    wait_idle();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_byte($sformatf("seq_byte%0d", i), seq_exp[i]);
`ifdef PIXEL_SPI_FRAME_CS_EN
    chk("seq_cs_rises", cs_rises - c0, 1);
`else
    chk("seq_cs_rises", cs_rises - c0, 4);
`endif
    chk("seq_cs_idle", bus.spi_cs_n_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
